// File: rtl/main_memory_arbiter_controller_if.sv
// Request/response bundle between the instruction/data L1 controllers and main memory.
// The range-error strobes exist only when MMC_RANGE_CHECK_EN is defined.
interface main_memory_arbiter_controller_if #(
  parameter int ADDR_BIT  = 32,
  parameter int BLOCK_BIT = 128
) ();
  logic                      ins_req_valid_i;
  logic [ADDR_BIT-1:0]       ins_req_addr_i;
  logic                      ins_resp_ready_o;
  logic [BLOCK_BIT-1:0]      ins_resp_data_o;
  logic                      dat_req_valid_i;
  logic                      dat_req_write_i;
  logic [ADDR_BIT-1:0]       dat_req_addr_i;
  logic [BLOCK_BIT-1:0]      dat_req_wdata_i;
  logic [BLOCK_BIT/32-1:0]   dat_req_wmask_i;
  logic                      dat_resp_ready_o;
  logic [BLOCK_BIT-1:0]      dat_resp_data_o;
`ifdef MMC_RANGE_CHECK_EN
  logic                      ins_resp_err_o;
  logic                      dat_resp_err_o;

  modport master (
    output ins_req_valid_i, ins_req_addr_i,
    output dat_req_valid_i, dat_req_write_i, dat_req_addr_i, dat_req_wdata_i, dat_req_wmask_i,
    input  ins_resp_ready_o, ins_resp_data_o, ins_resp_err_o,
    input  dat_resp_ready_o, dat_resp_data_o, dat_resp_err_o
  );

  modport slave (
    input  ins_req_valid_i, ins_req_addr_i,
    input  dat_req_valid_i, dat_req_write_i, dat_req_addr_i, dat_req_wdata_i, dat_req_wmask_i,
    output ins_resp_ready_o, ins_resp_data_o, ins_resp_err_o,
    output dat_resp_ready_o, dat_resp_data_o, dat_resp_err_o
  );
`else
  modport master (
    output ins_req_valid_i, ins_req_addr_i,
    output dat_req_valid_i, dat_req_write_i, dat_req_addr_i, dat_req_wdata_i, dat_req_wmask_i,
    input  ins_resp_ready_o, ins_resp_data_o,
    input  dat_resp_ready_o, dat_resp_data_o
  );

  modport slave (
    input  ins_req_valid_i, ins_req_addr_i,
    input  dat_req_valid_i, dat_req_write_i, dat_req_addr_i, dat_req_wdata_i, dat_req_wmask_i,
    output ins_resp_ready_o, ins_resp_data_o,
    output dat_resp_ready_o, dat_resp_data_o
  );
`endif
endinterface

// File: rtl/main_memory_arbiter_controller.sv
// Two-channel (instruction read / data read-write) block memory with round-robin arbitration,
// programmable latency and per-word write mask. Optional address range check: MMC_RANGE_CHECK_EN.
module main_memory_arbiter_controller #(
  parameter int ADDR_BIT  = 32,
  parameter int BLOCK_BIT = 128,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  main_memory_arbiter_controller_if.slave  bus
);
  localparam int WORDS = BLOCK_BIT / 32;
  localparam int OFS   = $clog2(BLOCK_BIT / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic                 w_respond;

  logic [BLOCK_BIT-1:0] r_mem [DEPTH];

  logic                 r_last_dat;
  logic                 r_sel_dat;
  logic                 r_write;
  logic                 r_err;
  logic [IDX_W-1:0]     r_idx;
  logic [BLOCK_BIT-1:0] r_wdata;
  logic [WORDS-1:0]     r_mask;
  logic [CNT_W-1:0]     r_cnt;

  logic                 r_ins_ready;
  logic                 r_dat_ready;
  logic [BLOCK_BIT-1:0] r_ins_data;
  logic [BLOCK_BIT-1:0] r_dat_data;

  logic                 w_ins_v;
  logic                 w_dat_v;
  logic                 w_grant_dat;
  logic [ADDR_BIT-1:0]  w_req_addr;
  logic                 w_req_err;
  logic [BLOCK_BIT-1:0] w_rdata;
  logic                 w_unused_addr;

  assign w_ins_v = bus.ins_req_valid_i;
  assign w_dat_v = bus.dat_req_valid_i;

  // Tie goes to whichever channel was not granted last; reset leaves the data channel as "last".
  assign w_grant_dat   = w_dat_v & (~w_ins_v | ~r_last_dat);
  assign w_req_addr    = w_grant_dat ? bus.dat_req_addr_i : bus.ins_req_addr_i;
  assign w_unused_addr = ^w_req_addr;

`ifdef MMC_RANGE_CHECK_EN
  assign w_req_err = |(w_req_addr >> (OFS + IDX_W));
`else
  assign w_req_err = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_respond    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ins_v | w_dat_v) begin
          w_accept     = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = S_RESPOND;
        end
      end
      S_RESPOND: begin
        w_respond    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Everything the transaction needs is captured here; requester inputs are ignored afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_dat <= 1'b1;
      r_sel_dat  <= 1'b0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_mask     <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_last_dat <= w_grant_dat;
        r_sel_dat  <= w_grant_dat;
        r_write    <= w_grant_dat & bus.dat_req_write_i;
        r_err      <= w_req_err;
        r_idx      <= w_req_addr[OFS +: IDX_W];
        r_wdata    <= bus.dat_req_wdata_i;
        r_mask     <= w_grant_dat ? bus.dat_req_wmask_i : '0;
        r_cnt      <= CNT_INIT;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_respond && r_write && !r_err) begin
      for (int w = 0; w < WORDS; w++) begin
        if (r_mask[w]) begin
          r_mem[r_idx][w*32 +: 32] <= r_wdata[w*32 +: 32];
        end
      end
    end
  end

  assign w_rdata = (r_write | r_err) ? '0 : r_mem[r_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ins_ready <= 1'b0;
      r_dat_ready <= 1'b0;
      r_ins_data  <= '0;
      r_dat_data  <= '0;
    end else begin
      r_ins_ready <= w_respond & ~r_sel_dat;
      r_dat_ready <= w_respond & r_sel_dat;
      if (w_respond && !r_sel_dat) begin
        r_ins_data <= w_rdata;
      end
      if (w_respond && r_sel_dat) begin
        r_dat_data <= w_rdata;
      end
    end
  end

  assign bus.ins_resp_ready_o = r_ins_ready;
  assign bus.dat_resp_ready_o = r_dat_ready;
  assign bus.ins_resp_data_o  = r_ins_data;
  assign bus.dat_resp_data_o  = r_dat_data;

`ifdef MMC_RANGE_CHECK_EN
  logic r_ins_err;
  logic r_dat_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ins_err <= 1'b0;
      r_dat_err <= 1'b0;
    end else begin
      r_ins_err <= w_respond & ~r_sel_dat & r_err;
      r_dat_err <= w_respond & r_sel_dat & r_err;
    end
  end

  assign bus.ins_resp_err_o = r_ins_err;
  assign bus.dat_resp_err_o = r_dat_err;
`endif
endmodule

// File: tb/tb_main_memory_arbiter_controller.sv
// Self-checking bench for main_memory_arbiter_controller: directed table, corner sequences,
// and a randomized two-channel run against a request-level reference model.
module tb_main_memory_arbiter_controller;
  localparam int LAT    = 2;
  localparam int RESP_K = LAT + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  main_memory_arbiter_controller_if #(.ADDR_BIT(32), .BLOCK_BIT(128)) bus ();

  main_memory_arbiter_controller #(
    .ADDR_BIT(32), .BLOCK_BIT(128), .DEPTH(256), .LATENCY(LAT)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [127:0] model_mem [256];

  typedef struct {
    bit           dat;
    bit           wr;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [3:0]   mask;
    logic [127:0] exp_data;
  } vec_t;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [3:0]   mask;
  } req_t;

  vec_t vecs [10];

  function automatic logic [127:0] pat(int i);
    logic [127:0] v;
    for (int w = 0; w < 4; w++) v[w*32 +: 32] = 32'hB000_0000 | 32'(i << 8) | 32'(w);
    return v;
  endfunction

  function automatic int blk(logic [31:0] a);
    return int'((a >> 4) & 32'hFF);
  endfunction

  function automatic bit model_err(logic [31:0] a);
`ifdef MMC_RANGE_CHECK_EN
    return (a >> 12) != 0;
`else
    return (a >> 12) != (a >> 12);
`endif
  endfunction

  task automatic model_write(logic [31:0] a, logic [127:0] d, logic [3:0] m);
    for (int w = 0; w < 4; w++)
      if (m[w]) model_mem[blk(a)][w*32 +: 32] = d[w*32 +: 32];
  endtask

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ins_req_valid_i = 1'b0;
    bus.ins_req_addr_i  = '0;
    bus.dat_req_valid_i = 1'b0;
    bus.dat_req_write_i = 1'b0;
    bus.dat_req_addr_i  = '0;
    bus.dat_req_wdata_i = '0;
    bus.dat_req_wmask_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated request; checks latency, data, single-cycle pulse and that the other channel stays quiet.
  task automatic run_single(bit dat, bit wr, logic [31:0] addr, logic [127:0] wdata,
                            logic [3:0] mask, logic [127:0] exp_data, bit exp_err, string name);
    int k;
    bit got;
    logic [127:0] data;
    @(negedge clk);
    if (dat) begin
      bus.dat_req_valid_i = 1'b1;
      bus.dat_req_write_i = wr;
      bus.dat_req_addr_i  = addr;
      bus.dat_req_wdata_i = wdata;
      bus.dat_req_wmask_i = mask;
    end else begin
      bus.ins_req_valid_i = 1'b1;
      bus.ins_req_addr_i  = addr;
    end
    k = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (dat) begin
        chk({name, " other_ready"}, bus.ins_resp_ready_o, 0);
        got = bus.dat_resp_ready_o;
      end else begin
        chk({name, " other_ready"}, bus.dat_resp_ready_o, 0);
        got = bus.ins_resp_ready_o;
      end
    end
    chk({name, " latency"}, got ? k : 0, RESP_K);
    data = dat ? bus.dat_resp_data_o : bus.ins_resp_data_o;
    chk({name, " data"}, data, exp_data);
`ifdef MMC_RANGE_CHECK_EN
    chk({name, " err"}, dat ? bus.dat_resp_err_o : bus.ins_resp_err_o, exp_err);
`endif
    if (dat) bus.dat_req_valid_i = 1'b0;
    else     bus.ins_req_valid_i = 1'b0;
    if (wr && !exp_err) model_write(addr, wdata, mask);
    @(negedge clk);
    chk({name, " pulse_end"}, dat ? bus.dat_resp_ready_o : bus.ins_resp_ready_o, 0);
  endtask

  // Randomized-phase state
  req_t         pend_i, pend_d, g_req;
  bit           has_i, has_d, busy, g_dat, last_dat, ri, rd, e, ei, ed;
  int           resp_cyc;
  logic [127:0] li, ld, rdata;

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
    if ($urandom_range(0, 3) == 0) a = a | ($urandom_range(1, 15) << 12);
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, when_k;
    bit rc;
    logic [127:0] cap;

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset ins_ready", bus.ins_resp_ready_o, 0);
    chk("reset dat_ready", bus.dat_resp_ready_o, 0);
    chk("reset ins_data", bus.ins_resp_data_o, 0);
    chk("reset dat_data", bus.dat_resp_data_o, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_single(1, 1, 32'(i * 16), pat(i), 4'hF, 0, 0, "init");
    do_reset();

    vecs[0] = '{0, 0, 32'h10, 128'h0, 4'h0, pat(1)};
    vecs[1] = '{1, 1, 32'h20, {4{32'hA5A5A5A5}}, 4'b0101, 128'h0};
    vecs[2] = '{1, 0, 32'h20, 128'h0, 4'h0, {32'hB000_0203, 32'hA5A5A5A5, 32'hB000_0201, 32'hA5A5A5A5}};
    vecs[3] = '{0, 0, 32'h2C, 128'h0, 4'h0, {32'hB000_0203, 32'hA5A5A5A5, 32'hB000_0201, 32'hA5A5A5A5}};
    vecs[4] = '{1, 1, 32'h30, {128{1'b1}}, 4'h0, 128'h0};
    vecs[5] = '{1, 0, 32'h34, 128'h0, 4'h0, pat(3)};
    vecs[6] = '{1, 1, 32'h47, 128'h1111_1111_2222_2222_3333_3333_4444_4444, 4'b1010, 128'h0};
    vecs[7] = '{0, 0, 32'h40, 128'h0, 4'h0, {32'h1111_1111, 32'hB000_0402, 32'h3333_3333, 32'hB000_0400}};
    vecs[8] = '{1, 1, 32'hF0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, 4'hF, 128'h0};
    vecs[9] = '{0, 0, 32'hFF, 128'h0, 4'h0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE};
    for (int i = 0; i < 10; i++)
      run_single(vecs[i].dat, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
                 vecs[i].exp_data, 0, $sformatf("vec%0d", i));

    // Out-of-range address: error response with the check, modulo-DEPTH alias without it.
    rc = 1'b0;
`ifdef MMC_RANGE_CHECK_EN
    rc = 1'b1;
`endif
    run_single(0, 0, 32'h1000, 0, 0, rc ? 128'h0 : model_mem[0], rc, "range_read");
    run_single(1, 1, 32'h1050, {4{32'h5A5A_0001}}, 4'hF, 0, rc, "range_write");
    run_single(1, 0, 32'h50, 0, 0, model_mem[5], 0, "range_after");

    // Inputs change right after acceptance: response must reflect the original read.
    @(negedge clk);
    bus.dat_req_valid_i = 1'b1;
    bus.dat_req_write_i = 1'b0;
    bus.dat_req_addr_i  = 32'h30;
    @(negedge clk);
    bus.dat_req_valid_i = 1'b0;
    bus.dat_req_write_i = 1'b1;
    bus.dat_req_addr_i  = 32'h40;
    pulses = 0;
    when_k = 0;
    cap = '0;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (bus.dat_resp_ready_o) begin
        pulses++;
        when_k = k;
        cap = bus.dat_resp_data_o;
      end
    end
    chk("latch pulses", pulses, 1);
    chk("latch when", when_k, RESP_K);
    chk("latch data", cap, model_mem[3]);
    idle_inputs();

    // Reset during the wait phase of a write: no response, block untouched.
    @(negedge clk);
    bus.dat_req_valid_i = 1'b1;
    bus.dat_req_write_i = 1'b1;
    bus.dat_req_addr_i  = 32'h50;
    bus.dat_req_wdata_i = {4{32'h5555_AAAA}};
    bus.dat_req_wmask_i = 4'hF;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("abort rst dat_ready", bus.dat_resp_ready_o, 0);
    chk("abort rst dat_data", bus.dat_resp_data_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort idle ins_ready", bus.ins_resp_ready_o, 0);
      chk("abort idle dat_ready", bus.dat_resp_ready_o, 0);
      chk("abort idle dat_data", bus.dat_resp_data_o, 0);
    end
    run_single(1, 0, 32'h50, 0, 0, model_mem[5], 0, "abort_readback");

    // Both channels requesting continuously from reset: grants alternate starting with instruction.
    do_reset();
    @(negedge clk);
    bus.ins_req_valid_i = 1'b1;
    bus.ins_req_addr_i  = 32'h10;
    bus.dat_req_valid_i = 1'b1;
    bus.dat_req_write_i = 1'b0;
    bus.dat_req_addr_i  = 32'h30;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk("rr ins_ready", bus.ins_resp_ready_o, (k % 8) == 4);
      chk("rr dat_ready", bus.dat_resp_ready_o, (k % 8) == 0);
      if ((k % 8) == 4) chk("rr ins_data", bus.ins_resp_data_o, model_mem[1]);
      if ((k % 8) == 0) chk("rr dat_data", bus.dat_resp_data_o, model_mem[3]);
    end
    idle_inputs();

    // Randomized traffic against the request-level model.
    do_reset();
    has_i = 0; has_d = 0; busy = 0; last_dat = 1; g_dat = 0;
    li = '0; ld = '0; ei = 0; ed = 0; resp_cyc = 0;
    for (int cyc = 1; cyc <= 1500; cyc++) begin
      @(negedge clk);
      ri = busy && cyc == resp_cyc && !g_dat;
      rd = busy && cyc == resp_cyc && g_dat;
      if (ri || rd) begin
        e = model_err(g_req.addr);
        rdata = (e || g_req.wr) ? 128'h0 : model_mem[blk(g_req.addr)];
        if (g_req.wr && !e) model_write(g_req.addr, g_req.wdata, g_req.mask);
        busy = 0;
        if (rd) begin
          ld = rdata; ed = e; has_d = 0; bus.dat_req_valid_i = 1'b0;
        end else begin
          li = rdata; ei = e; has_i = 0; bus.ins_req_valid_i = 1'b0;
        end
      end
      chk("rnd ins_ready", bus.ins_resp_ready_o, ri);
      chk("rnd dat_ready", bus.dat_resp_ready_o, rd);
      chk("rnd ins_data", bus.ins_resp_data_o, li);
      chk("rnd dat_data", bus.dat_resp_data_o, ld);
`ifdef MMC_RANGE_CHECK_EN
      chk("rnd ins_err", bus.ins_resp_err_o, ri && ei);
      chk("rnd dat_err", bus.dat_resp_err_o, rd && ed);
`endif
      if (!has_i && $urandom_range(0, 2) == 0) begin
        has_i = 1;
        pend_i = '{0, rand_addr(), 128'h0, 4'h0};
        bus.ins_req_valid_i = 1'b1;
        bus.ins_req_addr_i  = pend_i.addr;
      end
      if (!has_d && $urandom_range(0, 2) == 0) begin
        has_d = 1;
        pend_d = '{bit'($urandom_range(0, 1)), rand_addr(),
                   {$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15))};
        bus.dat_req_valid_i = 1'b1;
        bus.dat_req_write_i = pend_d.wr;
        bus.dat_req_addr_i  = pend_d.addr;
        bus.dat_req_wdata_i = pend_d.wdata;
        bus.dat_req_wmask_i = pend_d.mask;
      end
      if (!busy && (has_i || has_d)) begin
        g_dat    = has_d && (!has_i || !last_dat);
        last_dat = g_dat;
        g_req    = g_dat ? pend_d : pend_i;
        resp_cyc = cyc + RESP_K;
        busy     = 1;
      end
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
